// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues one-word reads to ram, buffers returns in a small ring, and hands words to decode.
// Issue to ir_valid takes 2 cycles; issue stops when buffered plus in-flight words reach BUF_DEPTH; redirect flushes wrong-path fetches.
module ifetch #(
  parameter logic [15:0] RESET_PC  = 16'h000F,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_out,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      pc;
  logic [PTR_W-1:0] head, tail, head_nxt;
  logic [CNT_W-1:0] count, rem;
  logic             inflight;
  logic [15:0]      inflight_pc;
  logic [15:0]      buf_word [BUF_DEPTH];
  logic [15:0]      buf_addr [BUF_DEPTH];
  logic [15:0]      ir_nxt, ir_pc_nxt;
  logic [CNT_W:0]   occ;
  logic             pop, push, issue;

  assign ir_valid = (count != '0);
  assign pop      = ir_valid & ir_ready;
  // A return landing in the redirect cycle belongs to the old path.
  assign push     = inflight & (state != FLUSH) & ~redirect;
  assign occ      = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
  assign issue    = (state == RUN) & en & ~redirect & (occ < DEPTH_V);
  assign mem_rd   = issue;
  assign mem_addr = pc;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    state_nxt = en ? RUN : IDLE;
        RUN:     state_nxt = en ? RUN : IDLE;
        FLUSH:   state_nxt = en ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ir/ir_pc follow the head after this cycle's pop/push, and hold when the buffer goes empty.
  always_comb begin
    rem       = count - CNT_W'(pop);
    head_nxt  = head + PTR_W'(pop);
    ir_nxt    = ir;
    ir_pc_nxt = ir_pc;
    if (!redirect) begin
      if (rem != '0) begin
        ir_nxt    = buf_word[head_nxt];
        ir_pc_nxt = buf_addr[head_nxt];
      end else if (push) begin
        ir_nxt    = mem_out;
        ir_pc_nxt = inflight_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      ir          <= '0;
      ir_pc       <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + 16'd1;
      end
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head_nxt;
        tail  <= tail + PTR_W'(push);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end
      ir    <= ir_nxt;
      ir_pc <= ir_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_word[tail] <= mem_out;
      buf_addr[tail] <= inflight_pc;
    end
  end

endmodule
